// File: rtl/voice_allocator.sv
// Voice allocator: assigns note-on/note-off events to oscillator slots with LRU stealing.

package voice_allocator_pkg;

    typedef enum logic [1:0] {
        WAVE_SIN = 2'd0,
        WAVE_TRI = 2'd1,
        WAVE_SAW = 2'd2,
        WAVE_SQR = 2'd3
    } wave_sel_t;

    typedef struct packed {
        logic [6:0] note;
        logic [6:0] velocity;
        wave_sel_t  wave_sel;
        logic       note_en;
    } dsp_to_osc_t;

endpackage

module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned AGE_W      = $clog2(NUM_VOICES)
) (
    input  logic                       clock,
    input  logic                       reset_l,
    input  logic                       event_valid,
    output logic                       event_ready,
    input  logic                       event_on,
    input  logic [6:0]                 event_note,
    input  logic [6:0]                 event_velocity,
    input  logic [1:0]                 wave_sel,
    output logic [17*NUM_VOICES-1:0]   voice_out,
    output logic [AGE_W:0]             active_count,
    output logic                       steal_pulse
);

    localparam int unsigned REC_W = $bits(dsp_to_osc_t);
    localparam logic [AGE_W-1:0] LAST = AGE_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_COMMIT} state_t;
    typedef enum logic [1:0] {EV_NONE, EV_ON, EV_OFF} ev_kind_t;

    state_t           state;
    logic [AGE_W-1:0] idx;
    ev_kind_t         ev_kind;
    logic [6:0]       ev_note;
    logic [6:0]       ev_vel;
    logic             match_found;
    logic [AGE_W-1:0] match_idx;
    logic             free_found;
    logic [AGE_W-1:0] free_idx;
    logic [AGE_W-1:0] oldest_idx;

    dsp_to_osc_t      voices  [NUM_VOICES];
    logic [AGE_W-1:0] age     [NUM_VOICES];
    logic [AGE_W-1:0] age_nxt [NUM_VOICES];

    logic [AGE_W-1:0] tgt;
    logic [AGE_W-1:0] tgt_age;
    logic             do_write;
    logic             do_off;
    logic             alloc_free;
    logic             steal;

    // Commit decision from the scan results, plus the resulting age ranks
    always_comb begin
        tgt        = match_idx;
        do_write   = 1'b0;
        do_off     = 1'b0;
        alloc_free = 1'b0;
        steal      = 1'b0;
        case (ev_kind)
            EV_ON: begin
                do_write = 1'b1;
                if (match_found) begin
                    tgt = match_idx;
                end else if (free_found) begin
                    tgt        = free_idx;
                    alloc_free = 1'b1;
                end else begin
                    tgt   = oldest_idx;
                    steal = 1'b1;
                end
            end
            EV_OFF:  do_off = match_found;
            default: ;
        endcase
        tgt_age = age[tgt];
        for (int i = 0; i < NUM_VOICES; i++) begin
            age_nxt[i] = age[i];
            if (do_write) begin
                if (AGE_W'(i) == tgt) begin
                    age_nxt[i] = '0;
                end else if (voices[i].note_en && (alloc_free || age[i] < tgt_age)) begin
                    age_nxt[i] = age[i] + AGE_W'(1);
                end
            end else if (do_off) begin
                if (voices[i].note_en && age[i] > tgt_age) begin
                    age_nxt[i] = age[i] - AGE_W'(1);
                end
            end
        end
    end

    // Handshake FSM, voice scan, voice/age commit and wave_sel broadcast
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state        <= ST_IDLE;
            event_ready  <= 1'b1;
            idx          <= '0;
            ev_kind      <= EV_NONE;
            ev_note      <= '0;
            ev_vel       <= '0;
            match_found  <= 1'b0;
            match_idx    <= '0;
            free_found   <= 1'b0;
            free_idx     <= '0;
            oldest_idx   <= '0;
            active_count <= '0;
            steal_pulse  <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voices[i] <= '0;
                age[i]    <= '0;
            end
        end else begin
            steal_pulse <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voices[i].wave_sel <= wave_sel_t'(wave_sel);
            end
            case (state)
                ST_IDLE: begin
                    if (event_valid && event_ready) begin
                        ev_note     <= event_note;
                        ev_vel      <= event_velocity;
                        if (event_note < 7'd21 || event_note > 7'd108) begin
                            ev_kind <= EV_NONE;
                        end else if (event_on && event_velocity != 7'd0) begin
                            ev_kind <= EV_ON;
                        end else begin
                            ev_kind <= EV_OFF;
                        end
                        match_found <= 1'b0;
                        match_idx   <= '0;
                        free_found  <= 1'b0;
                        free_idx    <= '0;
                        oldest_idx  <= '0;
                        idx         <= '0;
                        event_ready <= 1'b0;
                        state       <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (voices[idx].note_en && voices[idx].note == ev_note) begin
                        match_found <= 1'b1;
                        match_idx   <= idx;
                    end
                    if (!voices[idx].note_en && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                    if (voices[idx].note_en && age[idx] == LAST) begin
                        oldest_idx <= idx;
                    end
                    if (idx == LAST) begin
                        state <= ST_COMMIT;
                    end else begin
                        idx <= idx + AGE_W'(1);
                    end
                end
                ST_COMMIT: begin
                    if (do_write) begin
                        voices[tgt].note     <= ev_note;
                        voices[tgt].velocity <= ev_vel;
                        voices[tgt].note_en  <= 1'b1;
                    end
                    if (do_off) begin
                        voices[tgt].note_en <= 1'b0;
                    end
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        age[i] <= age_nxt[i];
                    end
                    if (alloc_free) begin
                        active_count <= active_count + (AGE_W+1)'(1);
                    end else if (do_off) begin
                        active_count <= active_count - (AGE_W+1)'(1);
                    end
                    steal_pulse <= steal;
                    event_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    event_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    // Flatten the voice registers onto the output bus
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_out
        assign voice_out[REC_W*gi +: REC_W] = voices[gi];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed test-plan scenarios plus randomized events vs. a queue-based model.

module tb_voice_allocator;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int VW = 17 * N;

    logic            clock = 1'b0;
    logic            reset_l = 1'b1;
    logic            event_valid = 1'b0;
    logic            event_ready;
    logic            event_on = 1'b0;
    logic [6:0]      event_note = '0;
    logic [6:0]      event_velocity = '0;
    logic [1:0]      wave_sel = '0;
    logic [VW-1:0]   voice_out;
    logic [AW:0]     active_count;
    logic            steal_pulse;

    voice_allocator #(.NUM_VOICES(N)) dut (
        .clock          (clock),
        .reset_l        (reset_l),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_on       (event_on),
        .event_note     (event_note),
        .event_velocity (event_velocity),
        .wave_sel       (wave_sel),
        .voice_out      (voice_out),
        .active_count   (active_count),
        .steal_pulse    (steal_pulse)
    );

    always #5 clock = ~clock;

    // Model: per-slot contents plus an ordering queue, newest voice at the front
    int          m_note [N];
    int          m_vel  [N];
    bit          m_en   [N];
    int          order[$];
    bit          exp_ready = 1'b1;
    bit          exp_steal = 1'b0;
    logic [1:0]  wave_q;
    int          total = 0;
    int          bad = 0;
    bit          chk_en = 1'b0;
    bit          rand_wave = 1'b0;

    always @(posedge clock or negedge reset_l)
        if (!reset_l) wave_q <= 2'd0;
        else          wave_q <= wave_sel;

    function automatic logic [16:0] rec(int n, int v, logic [1:0] w, bit e);
        return {7'(n), 7'(v), w, e};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[17*i +: 17] = rec(m_note[i], m_vel[i], wave_q, m_en[i]);
        return v;
    endfunction

    function automatic logic [16:0] vo(int i);
        return voice_out[17*i +: 17];
    endfunction

    task automatic check(string name, logic [VW-1:0] got, logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clock) begin
        if (chk_en) begin
            check("ready", VW'(event_ready), VW'(exp_ready));
            check("count", VW'(active_count), VW'(order.size()));
            check("steal", VW'(steal_pulse), VW'(exp_steal));
            check("voices", voice_out, exp_vec());
        end
    end

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_note[i] = 0; m_vel[i] = 0; m_en[i] = 1'b0;
        end
        order.delete();
        exp_ready = 1'b1;
        exp_steal = 1'b0;
    endtask

    task automatic drop_from_order(int v);
        for (int j = 0; j < order.size(); j++)
            if (order[j] == v) begin
                order.delete(j);
                break;
            end
    endtask

    task automatic apply(bit on, int note, int vel);
        int m;
        int f;
        int s;
        if (note < 21 || note > 108) return;
        m = -1;
        for (int i = 0; i < N; i++) if (m_en[i] && m_note[i] == note) m = i;
        if (on && vel != 0) begin
            if (m >= 0) begin
                m_vel[m] = vel;
                drop_from_order(m);
                order.push_front(m);
            end else begin
                f = -1;
                for (int i = N - 1; i >= 0; i--) if (!m_en[i]) f = i;
                if (f >= 0) begin
                    m_en[f] = 1'b1; m_note[f] = note; m_vel[f] = vel;
                    order.push_front(f);
                end else begin
                    s = order.pop_back();
                    m_note[s] = note; m_vel[s] = vel;
                    order.push_front(s);
                    exp_steal = 1'b1;
                end
            end
        end else if (m >= 0) begin
            m_en[m] = 1'b0;
            drop_from_order(m);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        exp_steal = 1'b0;
        if (rand_wave) wave_sel = 2'($urandom);
    endtask

    // Present one event; valid is held for a few busy cycles to show it is not re-accepted
    task automatic send(bit on, int note, int vel);
        int h;
        h = $urandom_range(0, N - 1);
        event_valid = 1'b1;
        event_on = on;
        event_note = 7'(note);
        event_velocity = 7'(vel);
        tick();
        exp_ready = 1'b0;
        if (h == 0) event_valid = 1'b0;
        for (int k = 1; k <= N + 1; k++) begin
            tick();
            if (k >= h) event_valid = 1'b0;
            if (k == N + 1) begin
                apply(on, note, vel);
                exp_ready = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        event_valid = 1'b0;
        model_reset();
        repeat (2) tick();
        reset_l = 1'b1;
        tick();
    endtask

    task automatic fill();
        for (int n = 60; n <= 67; n++) send(1'b1, n, 100);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] snap;
        #1;
        reset_l = 1'b0;
        model_reset();
        chk_en = 1'b1;
        tick();
        tick();
        reset_l = 1'b1;
        tick();
        check("rst_voices", voice_out, VW'(0));
        check("rst_count", VW'(active_count), VW'(0));
        check("rst_ready", VW'(event_ready), VW'(1));
        check("rst_steal", VW'(steal_pulse), VW'(0));

        wave_sel = 2'd3;
        tick();
        send(1'b1, 60, 100);
        check("first_v0", VW'(vo(0)), VW'(rec(60, 100, 2'd3, 1'b1)));
        check("first_count", VW'(active_count), VW'(1));

        for (int n = 61; n <= 67; n++) send(1'b1, n, 100);
        send(1'b1, 72, 90);
        check("steal_hi", VW'(steal_pulse), VW'(1));
        check("steal_v0", VW'(vo(0)), VW'(rec(72, 90, 2'd3, 1'b1)));
        check("steal_count", VW'(active_count), VW'(8));
        tick();
        check("steal_lo", VW'(steal_pulse), VW'(0));

        do_reset();
        fill();
        send(1'b0, 62, 0);
        check("off_v2", VW'(vo(2)), VW'(rec(62, 100, 2'd3, 1'b0)));
        check("off_count", VW'(active_count), VW'(7));
        send(1'b1, 80, 70);
        check("reuse_v2", VW'(vo(2)), VW'(rec(80, 70, 2'd3, 1'b1)));
        send(1'b1, 90, 80);
        check("steal_old_v0", VW'(vo(0)), VW'(rec(90, 80, 2'd3, 1'b1)));

        do_reset();
        fill();
        send(1'b1, 61, 50);
        check("retrig_v1", VW'(vo(1)), VW'(rec(61, 50, 2'd3, 1'b1)));
        check("retrig_nosteal", VW'(steal_pulse), VW'(0));
        check("retrig_count", VW'(active_count), VW'(8));
        send(1'b1, 99, 10);
        check("post_retrig_v0", VW'(vo(0)), VW'(rec(99, 10, 2'd3, 1'b1)));
        check("post_retrig_v1", VW'(vo(1)), VW'(rec(61, 50, 2'd3, 1'b1)));

        snap = voice_out;
        send(1'b1, 10, 100);
        check("oob_note", voice_out, snap);
        send(1'b0, 90, 0);
        check("off_unheld", voice_out, snap);
        send(1'b1, 64, 0);
        check("vel0_v4", VW'(vo(4)), VW'(rec(64, 100, 2'd3, 1'b0)));
        check("vel0_count", VW'(active_count), VW'(7));

        event_valid = 1'b1;
        event_on = 1'b1;
        event_note = 7'd70;
        event_velocity = 7'd33;
        tick();
        event_valid = 1'b0;
        exp_ready = 1'b0;
        tick();
        tick();
        reset_l = 1'b0;
        model_reset();
        #1;
        check("midscan_voices", voice_out, VW'(0));
        check("midscan_count", VW'(active_count), VW'(0));
        check("midscan_ready", VW'(event_ready), VW'(1));
        tick();
        reset_l = 1'b1;
        tick();

        rand_wave = 1'b1;
        for (int e = 0; e < 300; e++) begin
            bit on;
            int note;
            int vel;
            on = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 19) == 0) note = $urandom_range(0, 20);
            else note = $urandom_range(55, 70);
            vel = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
            send(on, note, vel);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        end
        rand_wave = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
